// File: rtl/reg_file_dbg_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_dbg_pkg
// Shared types and reset values for the register-file debug master.
//   dbg_op_e    : debug command opcodes as carried on cmd_op
//   dbg_state_e : states of the debug master FSM
//   RST_*       : reset values of the FSM state, latched opcode and cmd_ready
// ---------------------------------------------------------------------------
package reg_file_dbg_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_DUMP  = 2'd2,
      OP_FILL  = 2'd3
   } dbg_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DUMP = 3'd3,
      ST_FILL = 3'd4,
      ST_RESP = 3'd5
   } dbg_state_e;

   localparam dbg_state_e RST_STATE     = ST_IDLE;
   localparam dbg_op_e    RST_OP        = OP_READ;
   localparam logic       RST_CMD_READY = 1'b1;

endpackage

// File: rtl/rf_dbg_rsp_slot.sv
// ---------------------------------------------------------------------------
// rf_dbg_rsp_slot
// Single-entry valid/ready holding register for one debug response.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_load          capture i_addr/i_data/i_last/i_err and raise o_valid
//   i_ready         consumer accepts the held response when o_valid is high
//   o_valid         response present; payload stable until i_ready
//   o_addr/o_data/o_last/o_err  held response payload
// ---------------------------------------------------------------------------
module rf_dbg_rsp_slot
   import reg_file_dbg_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
   input  logic              i_err,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last,
   output logic              o_err
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic              r_err;

   // The FSM only loads while the slot is empty, so load takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_addr  <= i_addr;
         r_data  <= i_data;
         r_last  <= i_last;
         r_err   <= i_err;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_addr  = r_addr;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_err   = r_err;

endmodule

// File: rtl/reg_file_dbg_master.sv
// ---------------------------------------------------------------------------
// reg_file_dbg_master
// Debug-side initiator for the register file. Turns READ / WRITE / DUMP /
// FILL debug commands into register-file read/write port cycles and returns
// results on a valid/ready response stream.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_op/cmd_addr/cmd_data payload
//   rsp_valid/rsp_ready      response handshake; rsp_addr/rsp_data/rsp_last/rsp_err
//   rf_rd_addr, rf_rd_data   read port (combinational read data)
//   rf_wr_addr/data/enable   write port
//   busy                     FSM not idle
// ---------------------------------------------------------------------------
module reg_file_dbg_master
   import reg_file_dbg_pkg::*;
#(
   parameter int NUM_REGS      = 32,
   parameter int DATA_W        = 64,
   parameter int HARDWIRE_ZERO = 1,
   localparam int ADDR_W       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic [ADDR_W-1:0] rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              rf_wr_enable,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(NUM_REGS + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   // Only matters when NUM_REGS is not a power of two.
   function automatic logic [ADDR_W-1:0] clamp_addr(input logic [ADDR_W-1:0] a);
      if (a > LAST_IDX) return LAST_IDX;
      return a;
   endfunction

   dbg_state_e        r_state, w_next_state;
   dbg_op_e           r_op;
   logic [ADDR_W-1:0] r_idx, w_idx_next;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
   logic              r_fill_err, w_fill_err_next;

   logic              w_zero_blk;
   logic              w_accept;
   logic              w_rsp_fire;
   logic              w_load;
   logic [ADDR_W-1:0] w_ld_addr;
   logic [DATA_W-1:0] w_ld_data;
   logic              w_ld_last;
   logic              w_ld_err;

   assign w_zero_blk = (HARDWIRE_ZERO != 0) && (r_idx == '0);
   assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
   assign w_rsp_fire = rsp_valid && rsp_ready;
   assign w_cnt_inc  = r_cnt + CNT_W'(!w_zero_blk);
   assign busy       = (r_state != ST_IDLE);

   // State register and latched command / index / fill bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= RST_STATE;
         r_op       <= RST_OP;
         r_idx      <= '0;
         r_data     <= '0;
         r_cnt      <= '0;
         r_fill_err <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op       <= dbg_op_e'(cmd_op);
            r_idx      <= clamp_addr(cmd_addr);
            r_data     <= cmd_data;
            r_cnt      <= '0;
            r_fill_err <= 1'b0;
         end else begin
            r_idx      <= w_idx_next;
            r_cnt      <= w_cnt_next;
            r_fill_err <= w_fill_err_next;
         end
      end
   end

   // Next-state, port muxing and response-slot load
   always_comb begin
      w_next_state    = r_state;
      w_idx_next      = r_idx;
      w_cnt_next      = r_cnt;
      w_fill_err_next = r_fill_err;
      w_load          = 1'b0;
      w_ld_addr       = r_idx;
      w_ld_data       = r_data;
      w_ld_last       = 1'b1;
      w_ld_err        = 1'b0;
      cmd_ready       = 1'b0;
      rf_rd_addr      = '0;
      rf_wr_addr      = '0;
      rf_wr_data      = '0;
      rf_wr_enable    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            cmd_ready = RST_CMD_READY;
            if (cmd_valid) begin
               case (dbg_op_e'(cmd_op))
                  OP_READ:  w_next_state = ST_RD;
                  OP_WRITE: w_next_state = ST_WR;
                  OP_DUMP:  w_next_state = ST_DUMP;
                  default:  w_next_state = ST_FILL;
               endcase
            end
         end

         ST_RD: begin
            rf_rd_addr   = r_idx;
            w_load       = 1'b1;
            w_ld_data    = rf_rd_data;
            w_next_state = ST_RESP;
         end

         ST_WR: begin
            rf_wr_addr   = r_idx;
            rf_wr_data   = r_data;
            rf_wr_enable = !w_zero_blk;
            w_load       = 1'b1;
            w_ld_err     = w_zero_blk;
            w_next_state = ST_RESP;
         end

         ST_DUMP: begin
            rf_rd_addr   = r_idx;
            w_load       = 1'b1;
            w_ld_data    = rf_rd_data;
            w_ld_last    = (r_idx == LAST_IDX);
            w_next_state = ST_RESP;
         end

         ST_FILL: begin
            rf_wr_addr   = r_idx;
            rf_wr_data   = r_data;
            rf_wr_enable = !w_zero_blk;
            if (r_idx == LAST_IDX) begin
               w_load       = 1'b1;
               w_ld_data    = DATA_W'(w_cnt_inc);
               w_ld_err     = r_fill_err || w_zero_blk;
               w_next_state = ST_RESP;
            end else begin
               w_idx_next      = r_idx + 1'b1;
               w_cnt_next      = w_cnt_inc;
               w_fill_err_next = r_fill_err || w_zero_blk;
            end
         end

         ST_RESP: begin
            // A non-final DUMP response loops back for the next register.
            if (w_rsp_fire) begin
               if ((r_op == OP_DUMP) && !rsp_last) begin
                  w_idx_next   = r_idx + 1'b1;
                  w_next_state = ST_DUMP;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end

         default: w_next_state = ST_IDLE;
      endcase
   end

   rf_dbg_rsp_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_rsp_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_addr  (w_ld_addr),
      .i_data  (w_ld_data),
      .i_last  (w_ld_last),
      .i_err   (w_ld_err),
      .i_ready (rsp_ready),
      .o_valid (rsp_valid),
      .o_addr  (rsp_addr),
      .o_data  (rsp_data),
      .o_last  (rsp_last),
      .o_err   (rsp_err)
   );

endmodule

// File: tb/tb_reg_file_dbg_master.sv
module tb_reg_file_dbg_master;

   localparam logic [1:0] OPR = 2'd0, OPW = 2'd1, OPD = 2'd2, OPF = 2'd3;
   localparam logic [63:0] V_A = 64'h0123456789ABCDEF;
   localparam logic [63:0] V_Z = 64'h1111111111111111;
   localparam logic [63:0] V_H = 64'hFEDCBA9876543210;
   localparam logic [63:0] V_F = 64'hAAAA5555AAAA5555;
   localparam logic [63:0] V_R = 64'h5A5A5A5A5A5A5A5A;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [63:0] cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [4:0]  rsp_addr;
   logic [63:0] rsp_data;
   logic        rsp_last, rsp_err;
   logic [4:0]  rf_rd_addr, rf_wr_addr;
   logic [63:0] rf_rd_data, rf_wr_data;
   logic        rf_wr_enable, busy;

   logic [63:0] rf [32] = '{default: 64'h0};

   always #5 clk = ~clk;

   // Register file model: combinational read, write on rising edge
   assign rf_rd_data = rf[rf_rd_addr];
   always @(posedge clk) if (rf_wr_enable) rf[rf_wr_addr] <= rf_wr_data;

   reg_file_dbg_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .rf_wr_enable(rf_wr_enable), .busy(busy)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [63:0] data;
      logic        last;
      logic        err;
      bit          chk_addr;
   } rsp_t;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [63:0] exp_data;
      logic        exp_err;
      int          n_rsp;
      int          exp_pulses;
      int          exp_run;
      bit          chk_addr;
   } vec_t;

   rsp_t sbq[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;
   int   wr_pulses = 0;
   int   cur_run = 0;
   int   last_run = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write-pulse tracking and response scoreboard, sampled on falling edges
   task automatic monitor();
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rf_wr_enable) begin
            wr_pulses++;
            cur_run++;
         end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
         end
         if (rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got addr %0d data %h, none expected", rsp_addr, rsp_data);
            end else begin
               e = sbq.pop_front();
               if (e.chk_addr) chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_last", 64'(rsp_last), 64'(e.last));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
         end
      end
   endtask

   task automatic push(input logic [4:0] a, input logic [63:0] d, input logic l,
                       input logic er, input bit ca);
      rsp_t e;
      e.addr = a; e.data = d; e.last = l; e.err = er; e.chk_addr = ca;
      sbq.push_back(e);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [63:0] d);
      bit ok = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!busy && sbq.size() == 0) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle with 0 pending", busy, sbq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, bad;
      bit ok;
      vec_t v;
      logic [63:0] hold_data;

      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
      rsp_ready = 1'b1;
      fork monitor(); join_none

      #2;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_wr_enable", 64'(rf_wr_enable), 64'd0);
      chk("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
      #18 rst = 1'b1;

      //            op   addr   data  exp_data   err n  pulses run chk_addr
      vecs[0] = '{OPW, 5'd5,  V_A,  V_A,      1'b0, 1, 1, 0, 1'b1};
      vecs[1] = '{OPR, 5'd5,  '0,   V_A,      1'b0, 1, 0, 0, 1'b1};
      vecs[2] = '{OPW, 5'd0,  V_Z,  V_Z,      1'b1, 1, 0, 0, 1'b1};
      vecs[3] = '{OPR, 5'd0,  '0,   64'h0,    1'b0, 1, 0, 0, 1'b1};
      vecs[4] = '{OPW, 5'd31, V_H,  V_H,      1'b0, 1, 1, 0, 1'b1};
      vecs[5] = '{OPR, 5'd31, '0,   V_H,      1'b0, 1, 0, 0, 1'b1};
      vecs[6] = '{OPF, 5'd28, V_F,  64'd4,    1'b0, 1, 4, 4, 1'b0};
      vecs[7] = '{OPD, 5'd28, '0,   V_F,      1'b0, 4, 0, 0, 1'b1};
      vecs[8] = '{OPR, 5'd17, '0,   64'h0,    1'b0, 1, 0, 0, 1'b1};

      for (int i = 0; i < 9; i++) begin
         v  = vecs[i];
         p0 = wr_pulses;
         for (int k = 0; k < v.n_rsp; k++)
            push(v.addr + 5'(k), v.exp_data, (k == v.n_rsp - 1), v.exp_err, v.chk_addr);
         send_cmd(v.op, v.addr, v.data);
         wait_idle();
         chk($sformatf("v%0d_wr_pulses", i), 64'(wr_pulses - p0), 64'(v.exp_pulses));
         if (v.exp_run > 0)
            chk($sformatf("v%0d_wr_run", i), 64'(last_run), 64'(v.exp_run));
      end

      // READ latency: response appears on the 1st edge after acceptance
      push(5'd5, V_A, 1'b1, 1'b0, 1'b1);
      send_cmd(OPR, 5'd5, '0);
      @(negedge clk);
      chk("lat_rsp_valid_early", 64'(rsp_valid), 64'd0);
      chk("lat_rd_addr", 64'(rf_rd_addr), 64'd5);
      @(negedge clk);
      chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
      wait_idle();

      // DUMP 30 with response back-pressure
      rsp_ready = 1'b0;
      push(5'd30, V_F, 1'b0, 1'b0, 1'b1);
      push(5'd31, V_F, 1'b1, 1'b0, 1'b1);
      send_cmd(OPD, 5'd30, '0);
      ok = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; break; end
      end
      chk("stall_rsp_seen", 64'(ok), 64'd1);
      hold_data = rsp_data;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("stall_valid", 64'(rsp_valid), 64'd1);
         chk("stall_addr", 64'(rsp_addr), 64'd30);
         chk("stall_data", rsp_data, hold_data);
         chk("stall_no_read", 64'(rf_rd_addr), 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_idle();

      // cmd_valid held through a DUMP; queued READ follows the final handshake
      for (int k = 0; k < 4; k++) push(5'd28 + 5'(k), V_F, (k == 3), 1'b0, 1'b1);
      push(5'd10, 64'h0, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = OPD; cmd_addr = 5'd28; cmd_data = '0;
      @(posedge clk); #1;
      cmd_op = OPR; cmd_addr = 5'd10;
      bad = 0; ok = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready && rsp_last) begin ok = 1; break; end
         if (cmd_ready) bad++;
      end
      chk("held_final_seen", 64'(ok), 64'd1);
      chk("held_cmd_ready_low", 64'(bad), 64'd0);
      @(negedge clk);
      chk("held_cmd_ready_after", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("held_read_addr", 64'(rf_rd_addr), 64'd10);
      chk("held_read_busy", 64'(busy), 64'd1);
      wait_idle();

      // Reset during a FILL from 1: regs 1..3 written, reg 4 being written when reset hits
      send_cmd(OPF, 5'd1, V_R);
      ok = 0;
      for (int n = 0; n < 50; n++) begin
         if (rf_wr_enable && rf_wr_addr == 5'd4) begin ok = 1; break; end
         @(negedge clk);
      end
      chk("rstfill_reached", 64'(ok), 64'd1);
      #1 rst = 1'b0;
      #1;
      chk("rstfill_wr_enable", 64'(rf_wr_enable), 64'd0);
      chk("rstfill_busy", 64'(busy), 64'd0);
      chk("rstfill_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rstfill_r1", rf[1], V_R);
      chk("rstfill_r3", rf[3], V_R);
      chk("rstfill_r4", rf[4], 64'h0);
      chk("rstfill_r5", rf[5], V_A);
      chk("rstfill_r28", rf[28], V_F);
      rst = 1'b1;
      @(negedge clk);
      chk("rstfill_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rstfill_idle", 64'(busy), 64'd0);

      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
